// File: rtl/relu.sv
// relu -- registered ReLU on one IEEE-754 binary32 value: out = max(x, +0.0).
//
// Sits after the convolution/accumulate stage of the super-resolution datapath.
// Takes one operand per clock with no handshake or stall. Only the sign and
// special-value classes are inspected. There is no floating-point arithmetic.
//
// Parameters
//   LATENCY       pipeline depth from x to out in clock cycles (>= 1)
//   FLUSH_DENORM  1: positive subnormal inputs are output as +0.0
//   NAN_CANON     1: every NaN becomes the canonical quiet NaN 0x7FC00000
//                 0: positive NaNs pass unchanged, negative NaNs are canonicalised
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears every pipeline stage
//   x      binary32 operand ([31] sign, [30:23] exponent, [22:0] mantissa)
//   out    binary32 result, registered
module relu #(
   parameter int LATENCY      = 1,
   parameter bit FLUSH_DENORM = 1'b0,
   parameter bit NAN_CANON    = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] x,
   output logic [31:0] out
);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   if (LATENCY < 1) begin : g_bad_latency
      $error("relu: LATENCY must be at least 1");
   end

   logic [7:0]  exp_f;
   logic [22:0] man_f;
   logic        neg;
   logic        is_nan;
   logic        is_sub;
   logic [31:0] res;

   assign exp_f  = x[30:23];
   assign man_f  = x[22:0];
   assign neg    = x[31];
   assign is_nan = (exp_f == 8'hFF) && (man_f != 23'd0);
   assign is_sub = (exp_f == 8'h00) && (man_f != 23'd0);

   // NaN is tested before the sign. This way a negative NaN becomes the quiet
   // NaN instead of being clamped to zero. A negative input of any other class
   // gives +0.0, never -0.0.
   always_comb begin
      res = x;
      if (is_nan) begin
         if (NAN_CANON || neg) begin
            res = QNAN;
         end
      end else if (neg) begin
         res = 32'd0;
      end else if (FLUSH_DENORM && is_sub) begin
         res = 32'd0;
      end
   end

   logic [31:0] pipe [LATENCY];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe[i] <= 32'd0;
         end
      end else begin
         pipe[0] <= res;
         for (int i = 1; i < LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign out = pipe[LATENCY-1];

endmodule

// File: tb/tb_relu.sv
// Testbench for relu. Two instances share one input stream:
//   dut_a  defaults       (LATENCY=1, FLUSH_DENORM=0, NAN_CANON=1)
//   dut_b  alternate cfg  (LATENCY=3, FLUSH_DENORM=1, NAN_CANON=0)
// Inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_relu;

   logic        clk;
   logic        rst_n;
   logic [31:0] x;
   logic [31:0] out_a;
   logic [31:0] out_b;

   int checks   = 0;
   int failures = 0;

   // Reference pipelines: model_a is one deep, model_b[2] is the oldest of three.
   logic [31:0] model_a;
   logic [31:0] model_b [3];

   relu #(.LATENCY(1), .FLUSH_DENORM(1'b0), .NAN_CANON(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .x(x), .out(out_a)
   );

   relu #(.LATENCY(3), .FLUSH_DENORM(1'b1), .NAN_CANON(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .x(x), .out(out_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_relu(input logic [31:0] v, input bit flush, input bit canon);
      int unsigned ex;
      int unsigned mn;
      ex = (v >> 23) & 32'hFF;
      mn = v & 32'h7F_FFFF;
      if (ex == 255 && mn != 0) return (canon || v[31]) ? 32'h7FC00000 : v;
      if (v[31]) return 32'h0;
      if (flush && ex == 0 && mn != 0) return 32'h0;
      return v;
   endfunction

   task automatic model_clear();
      model_a = 32'h0;
      for (int i = 0; i < 3; i++) model_b[i] = 32'h0;
   endtask

   // Called on a falling edge: drives v, crosses one rising edge, and returns on the next falling edge.
   task automatic cycle(input logic [31:0] v);
      x = v;
      @(posedge clk);
      if (rst_n) begin
         model_a    = ref_relu(v, 1'b0, 1'b1);
         model_b[2] = model_b[1];
         model_b[1] = model_b[0];
         model_b[0] = ref_relu(v, 1'b1, 1'b0);
      end else begin
         model_clear();
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_clear();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         cycle(32'h3DCCCCCD);
         checks++;
         if (out_a !== 32'h0 || out_b !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold cyc=%0d a=%h b=%h expected 00000000", i, out_a, out_b);
         end
      end
      rst_n = 1'b1;
      cycle(32'h3DCCCCCD);
      checks++;
      if (out_a !== 32'h3DCCCCCD) begin
         failures++;
         $display("FAIL reset_release_a got=%h expected 3dcccccd", out_a);
      end
      checks++;
      if (out_b !== 32'h0) begin
         failures++;
         $display("FAIL reset_release_b_early got=%h expected 00000000", out_b);
      end
      cycle(32'h3DCCCCCD);
      cycle(32'h3DCCCCCD);
      checks++;
      if (out_b !== 32'h3DCCCCCD) begin
         failures++;
         $display("FAIL reset_release_b got=%h expected 3dcccccd", out_b);
      end
   endtask

   task automatic test_directed();
      logic [31:0] vin  [14] = '{32'h3DCCCCCD, 32'h3DDCCCCD, 32'h7F800000, 32'hFDCCCCCD,
                                 32'hFCCCCCCD, 32'h80000000, 32'hFF800000, 32'hFFC00001,
                                 32'h7F800001, 32'h00000001, 32'h7FFFFFFF, 32'h007FFFFF,
                                 32'h00800000, 32'h00000000};
      logic [31:0] expa [14] = '{32'h3DCCCCCD, 32'h3DDCCCCD, 32'h7F800000, 32'h00000000,
                                 32'h00000000, 32'h00000000, 32'h00000000, 32'h7FC00000,
                                 32'h7FC00000, 32'h00000001, 32'h7FC00000, 32'h007FFFFF,
                                 32'h00800000, 32'h00000000};
      logic [31:0] expb [14] = '{32'h3DCCCCCD, 32'h3DDCCCCD, 32'h7F800000, 32'h00000000,
                                 32'h00000000, 32'h00000000, 32'h00000000, 32'h7FC00000,
                                 32'h7F800001, 32'h00000000, 32'h7FFFFFFF, 32'h00000000,
                                 32'h00800000, 32'h00000000};
      for (int i = 0; i < 16; i++) begin
         cycle(i < 14 ? vin[i] : 32'h0);
         if (i < 14) begin
            checks++;
            if (out_a !== expa[i]) begin
               failures++;
               $display("FAIL directed_a x=%h got=%h expected %h", vin[i], out_a, expa[i]);
            end
         end
         if (i >= 2) begin
            checks++;
            if (out_b !== expb[i-2]) begin
               failures++;
               $display("FAIL directed_b x=%h got=%h expected %h", vin[i-2], out_b, expb[i-2]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] v;
      int unsigned sel;
      for (int i = 0; i < 300; i++) begin
         v   = $urandom;
         sel = $urandom_range(0, 3);
         if (sel == 0) v[30:23] = 8'h00;
         else if (sel == 1) v[30:23] = 8'hFF;
         if ($urandom_range(0, 7) == 0) v[22:0] = 23'd0;
         cycle(v);
         checks++;
         if (out_a !== model_a) begin
            failures++;
            $display("FAIL random_a x=%h got=%h expected %h", v, out_a, model_a);
         end
         checks++;
         if (out_b !== model_b[2]) begin
            failures++;
            $display("FAIL random_b got=%h expected %h", out_b, model_b[2]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      for (int i = 0; i < 20; i++) begin
         if (i == 10) begin
            // Assert reset away from any clock edge: outputs must clear at once.
            #2;
            rst_n = 1'b0;
            #1;
            checks++;
            if (out_a !== 32'h0 || out_b !== 32'h0) begin
               failures++;
               $display("FAIL async_reset a=%h b=%h expected 00000000", out_a, out_b);
            end
            model_clear();
            @(negedge clk);
            rst_n = 1'b1;
         end
         v = i[0] ? 32'hBF800000 : 32'h3F800000;
         cycle(v);
         checks++;
         if (out_a !== (i[0] ? 32'h0 : 32'h3F800000)) begin
            failures++;
            $display("FAIL alternate_a i=%0d got=%h expected %h", i, out_a, i[0] ? 32'h0 : 32'h3F800000);
         end
         checks++;
         if (out_b !== model_b[2]) begin
            failures++;
            $display("FAIL alternate_b i=%0d got=%h expected %h", i, out_b, model_b[2]);
         end
      end
   endtask

   initial begin
      rst_n = 1'b1;
      x     = 32'h0;
      model_clear();
      #2;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
